// File: rtl/pp_pkg.sv
// Shared constants and types for the Baugh-Wooley partial-product generator
// and the downstream compressor stage that consumes its pp words.
package pp_pkg;

    localparam int W_DEF     = 12;
    localparam int TAG_W_DEF = 4;
    localparam int DEPTH_DEF = 2;
    localparam int PP_W      = W_DEF * W_DEF;

    typedef logic [PP_W-1:0] pp_word_t;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // A one-entry buffer still needs a one-bit pointer to index storage.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One signed Baugh-Wooley partial-product row: a & b, with the sign column
// inverted on ordinary rows and the magnitude columns inverted on the last row.
module bw_pp_row
    import pp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic         b,
    input  logic         last,
    output logic [W-1:0] row
);

    logic [W-1:0] and_bits;
    logic [W-1:0] inv_mask;

    assign and_bits = a & {W{b}};

    // Sign-by-sign product stays positive, so the last row keeps its top bit.
    assign inv_mask = last ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};

    assign row = and_bits ^ inv_mask;

endmodule

// File: rtl/pp_gen_pipe.sv
// Signed Baugh-Wooley partial-product generator feeding a small FIFO of
// {pp, tag}; correction constants 2^W and 2^(2W-1) are left to the compressor.
module pp_gen_pipe
    import pp_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W*W-1:0]   out_pp,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [W*W-1:0]   pp_word_p0;
    logic [W*W-1:0]   pp_mem_p1  [DEPTH];
    logic [TAG_W-1:0] tag_mem_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;
    fifo_op_e         op;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stage p0: combinational partial products straight from the operands.
    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_row
            bw_pp_row #(.W(W)) u_row (
                .a    (in_a),
                .b    (in_b[i]),
                .last ((i == W - 1) ? 1'b1 : 1'b0),
                .row  (pp_word_p0[W*i +: W])
            );
        end
    endgenerate

    // Ready comes from registered occupancy only, never from out_ready.
    assign in_ready  = ~rst & (int'(cnt) < DEPTH);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        op = FIFO_IDLE;
        case ({push, pop})
            2'b01:   op = FIFO_POP;
            2'b10:   op = FIFO_PUSH;
            2'b11:   op = FIFO_BOTH;
            default: op = FIFO_IDLE;
        endcase
    end

    // Stage p1: FIFO storage, written on accept and read at rd_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 2'd0;
            for (int k = 0; k < DEPTH; k++) begin
                pp_mem_p1[k]  <= '0;
                tag_mem_p1[k] <= '0;
            end
        end else begin
            if (push) begin
                pp_mem_p1[wr_ptr]  <= pp_word_p0;
                tag_mem_p1[wr_ptr] <= in_tag;
                wr_ptr             <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case (op)
                FIFO_PUSH: cnt <= cnt + 2'd1;
                FIFO_POP:  cnt <= cnt - 2'd1;
                default:   cnt <= cnt;
            endcase
        end
    end

    assign out_pp  = pp_mem_p1[rd_ptr];
    assign out_tag = tag_mem_p1[rd_ptr];
    assign out_cnt = cnt;

endmodule

// File: doc/pp_gen_pipe.md
PP_GEN_PIPE -- requirements
Module: pp_gen_pipe

Interface
REQ-001 SHALL have parameters: W, default 12, operand width; DEPTH, default 2, output buffer entries; TAG_W, default 4, transaction tag width.
REQ-002 SHALL have ports, one per line:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous, active-high reset
  in_valid  input  1  operand pair valid
  in_ready  output  1  block can accept a pair
  in_a  input  W  multiplicand, two's complement
  in_b  input  W  multiplier, two's complement
  in_tag  input  TAG_W  opaque transaction tag
  out_valid  output  1  partial-product word valid
  out_ready  input  1  downstream compressor stage accepts
  out_pp  output  W*W  partial products, row i at bits [W*i +: W]
  out_tag  output  TAG_W  tag of out_pp
  out_cnt  output  2  buffer occupancy, 0..DEPTH
REQ-003 Clock and reset: one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 Transfer occurs on a rising clk edge when valid and ready are both 1; no other condition moves data.
REQ-005 Generation SHALL be signed Baugh-Wooley, i = row (bit of in_b), j = column (bit of in_a), weight 2^(i+j):
  i<W-1, j<W-1: a[j]&b[i]; i<W-1, j=W-1: ~(a[W-1]&b[i]); i=W-1, j<W-1: ~(a[j]&b[W-1]); i=j=W-1: a[W-1]&b[W-1].
REQ-006 Correction constants 2^W and 2^(2W-1) are NOT generated here; the downstream compressor adds them. The generated sum plus the constants, mod 2^(2W), SHALL equal in_a*in_b.
REQ-007 Partial products SHALL be computed combinationally from in_a/in_b and written into the buffer on accept, so no operand register is kept.
REQ-008 Buffer SHALL be a DEPTH-entry FIFO of {pp, tag} with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-009 in_ready = (out_cnt < DEPTH); in_ready SHALL NOT depend combinationally on out_ready.
REQ-010 out_valid = (out_cnt != 0); out_pp/out_tag SHALL present the entry at the read pointer.
REQ-011 Latency: a pair accepted at edge N SHALL appear on out_valid/out_pp after edge N if the FIFO was empty; otherwise ordering is strictly FIFO.
REQ-012 Simultaneous push and pop (0 < cnt < DEPTH): cnt unchanged, both pointers advance.
REQ-013 Full (cnt=DEPTH): in_ready=0, so no push; a pop in that cycle drops cnt to DEPTH-1, and in_ready rises the following cycle.
REQ-014 Empty (cnt=0): no pop; out_pp content is don't-care but SHALL hold its last written value, with no X.
REQ-015 While out_valid=1 and out_ready=0, out_pp/out_tag SHALL remain stable.
REQ-016 Tags SHALL be carried unmodified with their pp word.

Reset
REQ-017 On rst assertion, regardless of clock: cnt=0, pointers=0, out_valid=0, in_ready=0 while rst is held, and all buffer entries=0.
REQ-018 in_ready SHALL rise in the first cycle after rst deasserts; entries in flight at reset are discarded with no partial output.

Structure
REQ-019 Shared package pp_pkg SHALL hold W, TAG_W, DEPTH defaults and the pp word width constant W*W, shared with the compressor stage.
REQ-020 One sub-module, bw_pp_row, SHALL generate one Baugh-Wooley row (inputs a, b bit, last-row flag); the top instantiates W rows via generate. The FIFO is inline.

Verification
REQ-021 Test 1: a=3, b=5, tag=1, out_ready=1. Required: out_valid one cycle later; weighted pp sum + 2^12 + 2^23 mod 2^24 = 15; out_tag=1.
REQ-022 Test 2: a=12'hFFF, b=12'hFFF, then a=12'h800, b=12'h800, then a=12'h7FF, b=12'h800. Required: recomputed products 1, 0x400000 and 0xC00800 (-4192256) respectively.
REQ-023 Test 3: hold out_ready=0 and push 3 pairs. Required: 2 accepted, cnt=2, in_ready=0, third held; release out_ready, then all three exit in order with correct tags.
REQ-024 Test 4: cnt=1 with in_valid=1 and out_ready=1 for 10 cycles. Required: cnt stays 1, one output per cycle, no loss.
REQ-025 Test 5: assert rst mid-stream with cnt=2. Required: out_valid=0 immediately (asynchronous), no output after release, and the next accepted pair is output first.
REQ-026 Random: 10^5 random operands with random valid/ready. Required: every output matches the signed product through REQ-006 and tag order is preserved.
